// File: rtl/paced_bit_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : paced_bit_rx_if
// Description : Serial line and word-delivery signals of the paced bit
//               receiver. The master side drives the line and the enable;
//               the slave side (the receiver) returns words and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface paced_bit_rx_if #(
  parameter int DATA_BITS = 16
);

  logic                 Go;         // receive enable, low forces idle
  logic                 sdi;        // asynchronous serial line, idles high
  logic [DATA_BITS-1:0] data;       // last correctly framed word
  logic                 valid;      // one-cycle pulse when data updates
  logic                 frame_err;  // one-cycle pulse on a bad stop bit
  logic                 busy;       // receiver not idle

  modport master (
    output Go,
    output sdi,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  Go,
    input  sdi,
    output data,
    output valid,
    output frame_err,
    output busy
  );

endinterface : paced_bit_rx_if
`default_nettype wire

// File: rtl/paced_bit_rx.sv
`default_nettype none
// ============================================================================
// Module      : paced_bit_rx
// Description : Receiver for the LED/Pong bit link. Recovers idle-high NRZ
//               frames (1 start bit, DATA_BITS data bits LSB first, 1 stop
//               bit) at BIT_TICKS clocks per bit, delivers each good word
//               with a one-cycle valid pulse and flags bad stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module paced_bit_rx #(
  parameter int BIT_TICKS   = 28101,  // clk cycles per bit (>= 2)
  parameter int DATA_BITS   = 16,     // payload bits per frame (1..32)
  parameter int SYNC_STAGES = 2       // sdi synchroniser depth (>= 2)
) (
  input wire logic     clk,
  input wire logic     reset,         // synchronous, active low
  paced_bit_rx_if.slave bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int c_BCNT_W = $clog2(DATA_BITS + 1);

  // Last tick of a bit period: data and stop bits are sampled here.
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(BIT_TICKS - 1);
  // Middle of the start bit: re-checking here rejects short glitches and
  // places every later sample one full period on, near each bit centre.
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(BIT_TICKS / 2 - 1);
  localparam logic [c_BCNT_W-1:0] c_BIT_LAST  = c_BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic                   w_s_sdi;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_TICK_W-1:0]    r_tick;
  logic [c_TICK_W-1:0]    w_tick_nxt;
  logic [c_BCNT_W-1:0]    r_bitcnt;
  logic [c_BCNT_W-1:0]    w_bitcnt_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   w_shift_in;
  logic [DATA_BITS-1:0]   r_data;
  logic [DATA_BITS-1:0]   w_data_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic                   r_frame_err;
  logic                   w_frame_err_nxt;
  logic                   r_busy;

  // --------------------------------------------------------------------------
  // Line synchroniser; resets to the idle level so no false start follows
  // reset, and keeps the previous synchronised level for edge detection.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync   <= '1;
      r_s_prev <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.sdi};
      r_s_prev <= w_s_sdi;
    end
  end

  assign w_s_sdi = r_sync[SYNC_STAGES-1];
  assign w_fall  = r_s_prev & ~w_s_sdi;

  // --------------------------------------------------------------------------
  // Shift-in value: each new bit enters at the MSB so that after DATA_BITS
  // samples the first (LSB) bit has walked down to bit 0.
  // --------------------------------------------------------------------------
  generate
    if (DATA_BITS == 1) begin : g_shift_single
      assign w_shift_in = w_s_sdi;
    end else begin : g_shift_multi
      assign w_shift_in = {w_s_sdi, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and output decode for the frame receiver.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = (r_tick == c_TICK_LAST) ? '0 : r_tick + 1'b1;
    w_bitcnt_nxt    = r_bitcnt;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (!bus.Go) begin
      // Disabled: abandon any partial word silently.
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nxt = S_START;
          end
        end

        S_START: begin
          if (r_tick == c_TICK_MID) begin
            if (!w_s_sdi) begin
              w_state_nxt  = S_DATA;
              w_bitcnt_nxt = '0;
            end else begin
              // Line already back high: a glitch, not a start bit.
              w_state_nxt = S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (r_tick == c_TICK_LAST) begin
            w_shift_nxt = w_shift_in;
            if (r_bitcnt == c_BIT_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (r_tick == c_TICK_LAST) begin
            if (w_s_sdi) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              // Bad stop bit: keep the old word, wait out the low line.
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_BREAK;
            end
          end
        end

        S_BREAK: begin
          // A held-low line must return high before a new start counts.
          if (w_s_sdi) begin
            w_state_nxt = S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Every state entry starts a fresh bit period; idle holds the count at 0.
    if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) begin
      w_tick_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State, counters, word registers and registered status outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule : paced_bit_rx
`default_nettype wire

// File: tb/tb_paced_bit_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_paced_bit_rx
// Description : Self-checking bench for paced_bit_rx with BIT_TICKS=16,
//               DATA_BITS=8, SYNC_STAGES=2. Expected words and error events
//               are queued as frames are driven and matched as pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paced_bit_rx;

  localparam int BT  = 16;
  localparam int DB  = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + BT / 2 + (DB + 1) * BT + 1;  // 155

  logic clk   = 1'b0;
  logic reset = 1'b0;

  paced_bit_rx_if #(.DATA_BITS(DB)) bus ();

  paced_bit_rx #(
    .BIT_TICKS  (BT),
    .DATA_BITS  (DB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          is_err;
    logic [DB-1:0] d;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_valid = 0;
  int          n_err   = 0;
  int unsigned t_valid = 0;
  int unsigned t_fall  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the line level b for n clock edges; returns 1 time unit after an edge.
  task automatic hold(input logic b, input int n);
    bus.sdi = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    hold(1'b0, BT);
    for (int i = 0; i < DB; i++) hold(d[i], BT);
    hold(stop, BT);
  endtask

  // Output monitor: every valid / frame_err pulse must match the queue head.
  always @(negedge clk) begin
    if (bus.valid || bus.frame_err) begin
      chk("valid_err_exclusive", {31'b0, bus.valid & bus.frame_err}, 32'd0);
      if (bus.valid) begin
        n_valid++;
        t_valid = cyc;
      end
      if (bus.frame_err) n_err++;
      chk("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {31'b0, bus.frame_err}, {31'b0, mon_e.is_err});
        chk("pulse_data", {24'b0, bus.data}, {24'b0, mon_e.d});
      end
    end
  end

  // Hard time bound so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Go  = 1'b1;
    bus.sdi = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_data",  {24'b0, bus.data}, 32'd0);
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_err",   {31'b0, bus.frame_err}, 32'd0);
    chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 4);

    // Clean frame 0xA5 with exact latency
    sb.push_back('{is_err: 1'b0, d: 8'hA5});
    t_fall = cyc;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 4);
    chk("a5_latency", t_valid - t_fall, LAT);
    chk("a5_data",    {24'b0, bus.data}, 32'h0000_00A5);
    chk("a5_nvalid",  n_valid, 32'd1);
    chk("a5_nerr",    n_err, 32'd0);

    // Back-to-back frames 0x3C, 0xFF
    sb.push_back('{is_err: 1'b0, d: 8'h3C});
    sb.push_back('{is_err: 1'b0, d: 8'hFF});
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 4);
    chk("b2b_nvalid", n_valid, 32'd3);
    chk("b2b_data",   {24'b0, bus.data}, 32'h0000_00FF);

    // Three-cycle glitch
    hold(1'b0, 3);
    hold(1'b1, 2);
    chk("glitch_busy_hi", {31'b0, bus.busy}, 32'd1);
    hold(1'b1, 10);
    chk("glitch_busy_lo", {31'b0, bus.busy}, 32'd0);
    chk("glitch_nvalid",  n_valid, 32'd3);
    chk("glitch_nerr",    n_err, 32'd0);

    // Bad stop bit, line held low afterwards
    sb.push_back('{is_err: 1'b1, d: 8'hFF});
    send_frame(8'h5A, 1'b0);
    hold(1'b0, 40);
    chk("brk_busy",  {31'b0, bus.busy}, 32'd1);
    chk("brk_nerr",  n_err, 32'd1);
    chk("brk_data",  {24'b0, bus.data}, 32'h0000_00FF);
    hold(1'b1, 6);
    chk("brk_idle",  {31'b0, bus.busy}, 32'd0);
    chk("brk_nvalid", n_valid, 32'd3);
    hold(1'b1, 4);

    // Go dropped in the middle of data bit 4 of 0x81
    hold(1'b0, BT);
    hold(1'b1, BT);
    hold(1'b0, BT);
    hold(1'b0, BT);
    hold(1'b0, BT);
    hold(1'b0, BT / 2);
    bus.Go = 1'b0;
    hold(1'b0, 1);
    chk("go_busy", {31'b0, bus.busy}, 32'd0);
    hold(1'b1, 20);
    bus.Go = 1'b1;
    hold(1'b1, 4);
    chk("go_nvalid", n_valid, 32'd3);
    sb.push_back('{is_err: 1'b0, d: 8'h81});
    send_frame(8'h81, 1'b1);
    hold(1'b1, 4);
    chk("go_data", {24'b0, bus.data}, 32'h0000_0081);

    // Reset during the stop bit of 0x42
    hold(1'b0, BT);
    for (int i = 0; i < DB; i++) hold(logic'((8'h42 >> i) & 8'h01), BT);
    hold(1'b1, 6);
    reset = 1'b0;
    hold(1'b1, 1);
    chk("mrst_data",  {24'b0, bus.data}, 32'd0);
    chk("mrst_valid", {31'b0, bus.valid}, 32'd0);
    chk("mrst_busy",  {31'b0, bus.busy}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 9);
    hold(1'b1, 4);
    chk("mrst_nvalid", n_valid, 32'd4);
    sb.push_back('{is_err: 1'b0, d: 8'h01});
    send_frame(8'h01, 1'b1);
    hold(1'b1, 4);
    chk("post_rst_data",   {24'b0, bus.data}, 32'h0000_0001);
    chk("post_rst_nvalid", n_valid, 32'd5);

    // Every queued expectation must have been consumed
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("total_err",  n_err, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_paced_bit_rx
`default_nettype wire

// File: doc/paced_bit_rx.md
Name: paced_bit_rx

Overview:
- Serial receiver for the LED/Pong bit link; the receiving end of the transmitter paced by the aGo bit-period strobe.
- Recovers framed NRZ words from a single idle-high line using the same bit period as the sender. Each frame is 1 start bit (low), DATA_BITS data bits sent LSB first, and 1 stop bit (high).
- Delivers each word with a one-cycle valid pulse to downstream game/display logic, and flags framing errors.

Parameters:
- BIT_TICKS, 28101, clk cycles per bit; must match the transmitter's hold count + 1.
- DATA_BITS, 16, payload bits per frame (1..32).
- SYNC_STAGES, 2, flip-flops in the sdi synchroniser (>=2).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-low reset.
- Go, input, 1, receive enable; low forces idle.
- sdi, input, 1, asynchronous serial data line; idles high.
- data, output, DATA_BITS, last correctly framed word.
- valid, output, 1, one-cycle pulse when data is updated.
- frame_err, output, 1, one-cycle pulse on a bad stop bit.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; data=0; valid=0; frame_err=0; busy=0.
  - Bit counter and tick counter cleared; synchroniser chain set to 1.
- sdi passes through SYNC_STAGES flops to give s_sdi; all decisions use s_sdi. A falling edge is s_sdi==0 with the previous s_sdi==1.
- Tick counter width is clog2(BIT_TICKS). It counts 0..BIT_TICKS-1, then wraps to 0. It is reloaded to 0 on every state entry.
- IDLE:
  - On a falling edge with Go=1, go to START and clear the tick counter.
- START:
  - At tick == BIT_TICKS/2 - 1 (integer division), sample s_sdi.
  - If 0, go to DATA with bitcnt=0 and the tick counter cleared.
  - If 1, treat as a glitch: return to IDLE with no flag.
- DATA:
  - At each tick == BIT_TICKS-1, shift s_sdi into the shift register MSB side (LSB-first reception), then bitcnt++.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - At tick == BIT_TICKS-1, sample s_sdi.
  - If 1: data <= shift register and valid=1 on the next cycle; go to IDLE.
  - If 0: frame_err=1 on the next cycle; data is held; go to BREAK.
- BREAK:
  - Stay until s_sdi==1, then go to IDLE. A low line is never mistaken for a new start.
- Latency: valid rises (SYNC_STAGES + BIT_TICKS/2 + (DATA_BITS+1)*BIT_TICKS + 1) cycles after the sdi falling edge.
- Go deasserted in any state: go to IDLE next cycle. No valid or frame_err is issued, and the partial word is discarded. data is unchanged.
- reset asserted mid-frame: outputs take their reset values on that edge; any later falling edge starts a fresh frame.
- valid and frame_err are never high in the same cycle, and each lasts exactly one cycle.
- The next frame's falling edge may arrive in the very cycle after the return to IDLE (back-to-back frames); it must be accepted.
- busy = (state != IDLE), registered with the state.

Test Plan (BIT_TICKS=16, DATA_BITS=8, SYNC_STAGES=2):
- Reset, then send 0xA5 as a clean frame → one valid pulse; data=8'hA5 exactly 2+8+9*16+1=155 cycles after the falling edge; frame_err stays 0.
- Send 0x3C then 0xFF back-to-back with no idle gap → two valid pulses; data=0x3C, then data=0xFF.
- Drive sdi low for 3 cycles only (a glitch) → back to IDLE; no valid, no frame_err, busy falls within 10 cycles.
- Send 0x5A with the stop bit low, holding the line low for 40 more cycles, then high → one frame_err pulse; data keeps its previous value; no start detected until the line has been high and falls again.
- Assert Go=0 midway through the data bits of 0x81 → busy=0 next cycle; no valid. A following frame 0x81 with Go=1 → data=0x81.
- Assert reset=0 during the stop bit of a frame → data=0, valid=0 after that edge. Release reset and send 0x01 → data=0x01.
